risc_seq_ctrl: RTL
==================

// Module: risc_seq_ctrl
// PURPOSE
//  Multicycle control unit for the non-pipelined 32-bit RISC datapath. Sequences
//  fetch/decode/execute/write, owns the single memory port handshake, evaluates
//  branch conditions against the PSR, and counts retired instructions.
//  It sits between the datapath (IR, PC, register file, ALU, PSR) and unified memory.
// PARAMETERS
//  WIDTH    32  data path width; also the width of the retire counter
//  SBITS    5   PSR width {NEG,ZERO,PARITY,EVEN,CARRY} = psr[4:0]
//  MAXWAIT  15  max cycles mem_req may stay unacked before a bus error is raised
// PORTS
//  clk          in   1      clock; all state changes on the rising edge
//  reset        in   1      synchronous, active-high
//  run          in   1      start request; sampled only in IDLE
//  opcode       in   4      IR[31:28]
//  srctype      in   1      IR[27]; 0=reg/mem, 1=immediate
//  dsttype      in   1      IR[26]; 0=reg, 1=mem
//  ccode        in   4      IR[27:24]; branch condition
//  psr          in   SBITS  current processor status
//  mem_ack      in   1      memory completes the current request (1-cycle pulse)
//  alu_done     in   1      ALU result valid (MUL/ROT may take >1 cycle)
//  mem_req      out  1      memory request; held high until mem_ack
//  mem_we       out  1      1=write; valid while mem_req is high
//  mem_asel     out  2      address select: 0=PC, 1=SRC field, 2=DST field
//  ir_load      out  1      load IR from mem rdata (pulse)
//  pc_inc       out  1      PC<=PC+1 (pulse)
//  pc_load      out  1      PC<=DST field (pulse; taken branch)
//  alu_start    out  1      start ALU op (pulse)
//  rf_we        out  1      register file write to RFILE[DST] (pulse)
//  psr_update   out  1      clear PSR and load new condition codes (pulse)
//  halted       out  1      level; core is stopped
//  illegal_op   out  1      pulse; undefined opcode (10..15) was decoded
//  bus_err      out  1      level; MAXWAIT exceeded, sticky until reset
//  retired      out  WIDTH  count of completed instructions
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0, including retired and the wait counter.
//   Reset in any state, including mid-handshake, abandons the operation.
//  States: IDLE, FETCH, DECODE, MEMRD, MEMWR, EXEC, WRITE, HALT.
//  IDLE: run=1 -> FETCH.
//  FETCH: mem_req=1, asel=0. On mem_ack: ir_load=1 and pc_inc=1 in the same cycle -> DECODE.
//  DECODE (one cycle, by opcode):
//   NOP(0) -> FETCH. HLT(9) -> HALT.
//   BRA(1): pc_load=cond -> FETCH.
//   LD(2): srctype=1 -> rf_we=1, psr_update=1 -> FETCH; srctype=0 -> MEMRD.
//   STR(3) -> MEMWR.
//   ADD/MUL/CMP/SHF/ROT (4..8): alu_start=1 -> EXEC.
//   10..15: illegal_op=1 -> FETCH.
//  MEMRD: req, we=0, asel=1. On ack: rf_we=1, psr_update=1 -> FETCH.
//  MEMWR: req, we=1, asel=2. On ack: psr_update=1 -> FETCH.
//  EXEC: wait for alu_done. On alu_done: psr_update=1 -> WRITE.
//   alu_done arriving in the alu_start cycle is ignored.
//  WRITE: dsttype=0 -> rf_we=1 -> FETCH. dsttype=1 -> req, we=1, asel=2; on ack -> FETCH.
//  cond: ccode 0 =1; 1=psr[0] CARRY; 2=psr[1] EVEN; 3=psr[2] PARITY;
//   4=psr[3] ZERO; 5=psr[4] NEG; 6..15 =0 (not taken, not illegal).
//  retired +1 (mod 2^WIDTH, wraps) on every transition into FETCH from DECODE,
//   MEMRD, MEMWR or WRITE. illegal_op cycles and HALT entry do not count.
//  Wait counter: cleared when mem_req rises or mem_ack arrives; +1 each unacked req cycle.
//   Reaching MAXWAIT -> bus_err=1, drop req -> HALT.
//  mem_ack while mem_req=0 is ignored. mem_req, we and asel are stable until ack.
//  HALT: halted=1; run is ignored; only reset exits.
// STRUCTURE
//  risc_defs_pkg: opcode constants, ccode constants, PSR bit indices,
//   state encoding, mem_asel encodings.
//  Sub-module risc_cond_check: combinational (ccode, psr) -> cond.
//  Remainder: a single FSM plus the wait and retire counters.
// TESTING
//  1. reset; run=1; NOP, HLT, mem_ack 1 cycle after each req ->
//     2 fetches, retired=1, halted=1 from the 7th clk.
//  2. psr=5'b01000; BRA ccode=4 -> pc_load pulse.
//     Repeat with ccode=5 -> no pc_load; ccode=12 -> no pc_load, illegal_op=0.
//  3. LD srctype=0 with ack delayed 3 cycles -> mem_req high 4 cycles,
//     asel=1, then one rf_we + psr_update pulse.
//  4. MUL dsttype=1, alu_done 5 cycles after alu_start ->
//     WRITE issues we=1 asel=2; retired increments once.
//  5. FETCH with no ack, MAXWAIT=15 -> bus_err and halted after 15 req cycles;
//     reset clears both; run restarts at FETCH.
//  6. reset asserted mid-EXEC -> next cycle IDLE, all outputs 0, retired=0;
//     opcode 13 -> illegal_op pulse, retired unchanged.

Source files
------------

// File: rtl/risc_defs_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : risc_defs_pkg
//  Purpose  : Shared encodings for the multicycle RISC control unit: opcodes,
//             branch condition codes, PSR bit positions, memory address
//             selects and the sequencer state type.
//  Revision : 1.0  initial release
// ============================================================================
package risc_defs_pkg;

    // Opcodes carried in IR[31:28]; 10..15 are undefined
    localparam logic [3:0] c_op_nop = 4'd0;
    localparam logic [3:0] c_op_bra = 4'd1;
    localparam logic [3:0] c_op_ld  = 4'd2;
    localparam logic [3:0] c_op_str = 4'd3;
    localparam logic [3:0] c_op_add = 4'd4;
    localparam logic [3:0] c_op_mul = 4'd5;
    localparam logic [3:0] c_op_cmp = 4'd6;
    localparam logic [3:0] c_op_shf = 4'd7;
    localparam logic [3:0] c_op_rot = 4'd8;
    localparam logic [3:0] c_op_hlt = 4'd9;

    // Branch condition codes carried in IR[27:24]; 6..15 are never taken
    localparam logic [3:0] c_cc_always = 4'd0;
    localparam logic [3:0] c_cc_carry  = 4'd1;
    localparam logic [3:0] c_cc_even   = 4'd2;
    localparam logic [3:0] c_cc_parity = 4'd3;
    localparam logic [3:0] c_cc_zero   = 4'd4;
    localparam logic [3:0] c_cc_neg    = 4'd5;

    // Bit positions inside the PSR {NEG,ZERO,PARITY,EVEN,CARRY}
    localparam int c_psr_carry  = 0;
    localparam int c_psr_even   = 1;
    localparam int c_psr_parity = 2;
    localparam int c_psr_zero   = 3;
    localparam int c_psr_neg    = 4;

    // Memory address source selects
    localparam logic [1:0] c_asel_pc  = 2'd0;
    localparam logic [1:0] c_asel_src = 2'd1;
    localparam logic [1:0] c_asel_dst = 2'd2;

    // Sequencer states
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_MEMRD  = 3'd3,
        S_MEMWR  = 3'd4,
        S_EXEC   = 3'd5,
        S_WRITE  = 3'd6,
        S_HALT   = 3'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/risc_cond_check.sv
`default_nettype none
// ============================================================================
//  Module   : risc_cond_check
//  Purpose  : Combinational branch condition evaluation of a condition code
//             against the current processor status register.
//  Revision : 1.0  initial release
// ============================================================================
module risc_cond_check
    import risc_defs_pkg::*;
#(
    parameter int SBITS = 5
) (
    input  logic [3:0]       ccode,
    input  logic [SBITS-1:0] psr,
    output logic             cond
);

    // Select the PSR flag named by the condition code; unknown codes are not taken
    always_comb begin
        cond = 1'b0;
        case (ccode)
            c_cc_always: cond = 1'b1;
            c_cc_carry:  cond = psr[c_psr_carry];
            c_cc_even:   cond = psr[c_psr_even];
            c_cc_parity: cond = psr[c_psr_parity];
            c_cc_zero:   cond = psr[c_psr_zero];
            c_cc_neg:    cond = psr[c_psr_neg];
            default:     cond = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/risc_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : risc_seq_ctrl
//  Purpose  : Multicycle control unit for the non-pipelined 32-bit RISC core.
//             Sequences fetch/decode/execute/write, owns the memory request
//             handshake with a bus-error watchdog, evaluates branches and
//             counts retired instructions.
//  Revision : 1.0  initial release
// ============================================================================
module risc_seq_ctrl
    import risc_defs_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SBITS   = 5,
    parameter int MAXWAIT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [3:0]       opcode,
    input  logic             srctype,
    input  logic             dsttype,
    input  logic [3:0]       ccode,
    input  logic [SBITS-1:0] psr,
    input  logic             mem_ack,
    input  logic             alu_done,
    output logic             mem_req,
    output logic             mem_we,
    output logic [1:0]       mem_asel,
    output logic             ir_load,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             alu_start,
    output logic             rf_we,
    output logic             psr_update,
    output logic             halted,
    output logic             illegal_op,
    output logic             bus_err,
    output logic [WIDTH-1:0] retired
);

    // Wide enough to hold MAXWAIT; the last legal count triggers the bus error
    localparam int                  c_wait_w    = $clog2(MAXWAIT + 1);
    localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(MAXWAIT - 1);

    state_t              r_state;
    state_t              w_next;
    logic [c_wait_w-1:0] r_wait;
    logic                r_bus_err;
    logic [WIDTH-1:0]    r_retired;
    logic                w_cond;
    logic                w_retire;
    logic                w_timeout;

    risc_cond_check #(
        .SBITS (SBITS)
    ) u_cond (
        .ccode (ccode),
        .psr   (psr),
        .cond  (w_cond)
    );

    // State register; reset abandons any operation in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and control outputs; memory outputs depend only on state so they hold until ack
    always_comb begin
        w_next     = r_state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_asel   = c_asel_pc;
        ir_load    = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        alu_start  = 1'b0;
        rf_we      = 1'b0;
        psr_update = 1'b0;
        halted     = 1'b0;
        illegal_op = 1'b0;
        w_retire   = 1'b0;
        w_timeout  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_next = S_FETCH;
                end
            end

            S_FETCH: begin
                mem_req  = 1'b1;
                mem_asel = c_asel_pc;
                if (mem_ack) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    w_next  = S_DECODE;
                end
            end

            S_DECODE: begin
                case (opcode)
                    c_op_nop: begin
                        w_next   = S_FETCH;
                        w_retire = 1'b1;
                    end
                    c_op_bra: begin
                        pc_load  = w_cond;
                        w_next   = S_FETCH;
                        w_retire = 1'b1;
                    end
                    c_op_ld: begin
                        if (srctype) begin
                            rf_we      = 1'b1;
                            psr_update = 1'b1;
                            w_next     = S_FETCH;
                            w_retire   = 1'b1;
                        end else begin
                            w_next = S_MEMRD;
                        end
                    end
                    c_op_str: begin
                        w_next = S_MEMWR;
                    end
                    c_op_add, c_op_mul, c_op_cmp, c_op_shf, c_op_rot: begin
                        alu_start = 1'b1;
                        w_next    = S_EXEC;
                    end
                    c_op_hlt: begin
                        w_next = S_HALT;
                    end
                    default: begin
                        illegal_op = 1'b1;
                        w_next     = S_FETCH;
                    end
                endcase
            end

            S_MEMRD: begin
                mem_req  = 1'b1;
                mem_asel = c_asel_src;
                if (mem_ack) begin
                    rf_we      = 1'b1;
                    psr_update = 1'b1;
                    w_next     = S_FETCH;
                    w_retire   = 1'b1;
                end
            end

            S_MEMWR: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_asel = c_asel_dst;
                if (mem_ack) begin
                    psr_update = 1'b1;
                    w_next     = S_FETCH;
                    w_retire   = 1'b1;
                end
            end

            S_EXEC: begin
                // alu_done seen during the alu_start cycle never reaches here
                if (alu_done) begin
                    psr_update = 1'b1;
                    w_next     = S_WRITE;
                end
            end

            S_WRITE: begin
                if (!dsttype) begin
                    rf_we    = 1'b1;
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end else begin
                    mem_req  = 1'b1;
                    mem_we   = 1'b1;
                    mem_asel = c_asel_dst;
                    if (mem_ack) begin
                        w_next   = S_FETCH;
                        w_retire = 1'b1;
                    end
                end
            end

            S_HALT: begin
                halted = 1'b1;
            end

            default: begin
                w_next = S_IDLE;
            end
        endcase

        // Watchdog: the final unacknowledged request cycle drops the core into HALT
        if (mem_req && !mem_ack && (r_wait == c_wait_last)) begin
            w_timeout = 1'b1;
            w_next    = S_HALT;
        end
    end

    // Wait counter: restarts whenever no request is pending or an ack completes one
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait <= '0;
        end else if (!mem_req || mem_ack) begin
            r_wait <= '0;
        end else begin
            r_wait <= r_wait + 1'b1;
        end
    end

    // Sticky bus error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bus_err <= 1'b0;
        end else if (w_timeout) begin
            r_bus_err <= 1'b1;
        end
    end

    // Retired instruction counter, wraps modulo 2^WIDTH
    always_ff @(posedge clk) begin
        if (reset) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + 1'b1;
        end
    end

    assign bus_err = r_bus_err;
    assign retired = r_retired;

endmodule
`default_nettype wire
